// File: rtl/mem_access_ctrl_if.sv
// Request/response handshake bundle between a CPU load/store unit and mem_access_ctrl.
// The CPU side is the master; the controller is the slave.
interface mem_access_ctrl_if #(
   parameter int unsigned N = 32,
   parameter int unsigned M = 32
);
   logic         req_valid;
   logic         req_ready;
   logic         req_we;
   logic [1:0]   req_size;
   logic         req_signed;
   logic [M-1:0] req_addr;
   logic [N-1:0] req_wdata;
   logic         rsp_valid;
   logic         rsp_ready;
   logic [N-1:0] rsp_rdata;
   logic         rsp_err;

   modport master (
      output req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store front end for a single-port synchronous RAM: byte/half/word accesses,
// read-modify-write for sub-word stores, sign/zero extension, alignment/range checks.
module mem_access_ctrl #(
   parameter int unsigned N         = 32,
   parameter int unsigned M         = 32,
   parameter int unsigned MEM_DEPTH = 32
) (
   input  logic                 clock,
   input  logic                 reset,
   mem_access_ctrl_if.slave     bus,
   output logic [M-1:0]         ram_address,
   output logic [N-1:0]         ram_data,
   output logic                 ram_wren,
   input  logic [N-1:0]         ram_q
);

   typedef enum logic [2:0] {StIdle, StRd, StRdWait, StWr, StResp} state_t;

   localparam logic [M-1:0] DepthLim = M'(MEM_DEPTH);

   state_t       state_q;
   logic         we_q;
   logic [1:0]   size_q;
   logic         sgn_q;
   logic [1:0]   lane_q;
   logic [N-1:0] wdata_q;
   logic [M-1:0] addr_q;
   logic [N-1:0] data_q;
   logic         rsp_valid_q;
   logic [N-1:0] rsp_rdata_q;
   logic         rsp_err_q;

   logic         req_err;
   logic [N-1:0] rd_shift;
   logic [N-1:0] rd_ext;
   logic [N-1:0] wr_shift;
   logic [3:0]   be;
   logic [N-1:0] merged;

   always_comb begin
      req_err = 1'b0;
      unique case (bus.req_size)
         2'b00:   req_err = 1'b0;
         2'b01:   req_err = bus.req_addr[0];
         2'b10:   req_err = (bus.req_addr[1:0] != 2'b00);
         default: req_err = 1'b1;
      endcase
      if ({2'b00, bus.req_addr[M-1:2]} >= DepthLim) req_err = 1'b1;
   end

   // Load path: shift the addressed lane down to bit 0, then extend.
   always_comb begin
      rd_shift = ram_q >> {lane_q, 3'b000};
      unique case (size_q)
         2'b00:   rd_ext = {{24{sgn_q & rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   rd_ext = {{16{sgn_q & rd_shift[15]}}, rd_shift[15:0]};
         default: rd_ext = rd_shift;
      endcase
   end

   // Store path: byte enables select which lanes of the old word get replaced.
   always_comb begin
      wr_shift = wdata_q << {lane_q, 3'b000};
      unique case (size_q)
         2'b00:   be = 4'b0001 << lane_q;
         2'b01:   be = 4'b0011 << {lane_q[1], 1'b0};
         default: be = 4'b1111;
      endcase
      merged = ram_q;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) merged[8*k +: 8] = wr_shift[8*k +: 8];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= StIdle;
         we_q        <= 1'b0;
         size_q      <= 2'b00;
         sgn_q       <= 1'b0;
         lane_q      <= 2'b00;
         wdata_q     <= '0;
         addr_q      <= '0;
         data_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.req_valid) begin
                  we_q    <= bus.req_we;
                  size_q  <= bus.req_size;
                  sgn_q   <= bus.req_signed;
                  lane_q  <= bus.req_addr[1:0];
                  wdata_q <= bus.req_wdata;
                  addr_q  <= {2'b00, bus.req_addr[M-1:2]};
                  if (req_err) begin
                     state_q     <= StResp;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= '0;
                  end else if (bus.req_we && bus.req_size == 2'b10) begin
                     state_q <= StWr;
                     data_q  <= bus.req_wdata;
                  end else begin
                     state_q <= StRd;
                  end
               end
            end
            StRd: state_q <= StRdWait;
            StRdWait: begin
               if (we_q) begin
                  state_q <= StWr;
                  data_q  <= merged;
               end else begin
                  state_q     <= StResp;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= rd_ext;
               end
            end
            StWr: begin
               state_q     <= StResp;
               data_q      <= '0;
               rsp_valid_q <= 1'b1;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= '0;
            end
            StResp: begin
               if (bus.rsp_ready) begin
                  state_q     <= StIdle;
                  rsp_valid_q <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Gating with reset guarantees no RAM write lands in a reset cycle.
   assign ram_wren      = (state_q == StWr) & ~reset;
   assign ram_address   = addr_q;
   assign ram_data      = data_q;
   assign bus.req_ready = (state_q == StIdle) & ~reset;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed scenarios plus random traffic checked against a
// byte-addressed reference memory.
module tb_mem_access_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        clr   = 1'b1;
   logic [31:0] ram_address;
   logic [31:0] ram_data;
   logic        ram_wren;
   logic [31:0] ram_q;
   logic [31:0] mem [0:31];
   logic [7:0]  refb [0:127];
   int          wren_cnt = 0;
   int          checks   = 0;
   int          failures = 0;

   mem_access_ctrl_if #(.N(32), .M(32)) bus ();

   mem_access_ctrl #(.N(32), .M(32), .MEM_DEPTH(32)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus),
      .ram_address (ram_address),
      .ram_data    (ram_data),
      .ram_wren    (ram_wren),
      .ram_q       (ram_q)
   );

   always #5 clock = ~clock;

   // Synchronous single-port RAM: q valid the cycle after the address.
   always @(posedge clock) begin
      if (clr) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
         ram_q <= '0;
      end else begin
         if (ram_wren && ram_address < 32) mem[ram_address[4:0]] <= ram_data;
         ram_q <= (ram_address < 32) ? mem[ram_address[4:0]] : 32'h0;
      end
      if (ram_wren) wren_cnt <= wren_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_word(input int idx);
      return {refb[4*idx+3], refb[4*idx+2], refb[4*idx+1], refb[4*idx]};
   endfunction

   // Reference: bytes in a flat array, legality from plain arithmetic.
   function automatic void ref_access(input logic we, input logic [1:0] size, input logic sgn,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] rdata, output logic err);
      int nbytes = 1 << size;
      logic [31:0] val = 0;
      err = (size == 2'd3) || (addr % nbytes != 0) || (addr / 4 >= 32);
      rdata = 0;
      if (err) return;
      if (we) begin
         for (int i = 0; i < nbytes; i++) refb[addr + i] = wdata[8*i +: 8];
      end else begin
         for (int i = 0; i < nbytes; i++) val = val | (32'(refb[addr + i]) << (8 * i));
         if (sgn && nbytes < 4 && val[8*nbytes-1]) val = val | ~((32'd1 << (8 * nbytes)) - 1);
         rdata = val;
      end
   endfunction

   // Called at a negedge; returns at a negedge with the controller idle again.
   task automatic txn(input string tag, input logic we, input logic [1:0] size, input logic sgn,
                      input logic [31:0] addr, input logic [31:0] wdata, input int hold);
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          exp_lat;
      int          lat = 0;
      int          w0;
      int          guard = 0;
      ref_access(we, size, sgn, addr, wdata, exp_rdata, exp_err);
      exp_lat = exp_err ? 1 : (we && size == 2'd2) ? 2 : we ? 4 : 3;
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_size   = size;
      bus.req_signed = sgn;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      while (!bus.req_ready && guard < 20) begin
         @(negedge clock);
         guard++;
      end
      if (guard >= 20) check({tag, "_accept_timeout"}, 32'(bus.req_ready), 32'd1);
      w0 = wren_cnt;
      @(posedge clock);
      @(negedge clock);
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'($urandom);
      bus.req_size   = 2'($urandom);
      bus.req_addr   = $urandom;
      bus.req_wdata  = $urandom;
      lat = 1;
      while (!bus.rsp_valid && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check({tag, "_rdata"}, bus.rsp_rdata, exp_rdata);
      check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
      for (int h = 0; h < hold; h++) begin
         @(negedge clock);
         check({tag, "_hold_valid"}, 32'(bus.rsp_valid), 32'd1);
         check({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rdata);
         check({tag, "_hold_ready"}, 32'(bus.req_ready), 32'd0);
      end
      bus.rsp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      bus.rsp_ready = 1'b0;
      check({tag, "_valid_drop"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_wren_count"}, 32'(wren_cnt - w0), (!exp_err && we) ? 32'd1 : 32'd0);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_size   = 2'b00;
      bus.req_signed = 1'b0;
      bus.req_addr   = '0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b0;
      for (int i = 0; i < 128; i++) refb[i] = 8'h00;

      @(negedge clock);
      clr = 1'b0;
      bus.req_valid = 1'b1;  // must not be accepted while reset is high
      @(negedge clock);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
      check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check("rst_ram_wren", 32'(ram_wren), 32'd0);
      check("rst_ram_address", ram_address, 32'd0);
      check("rst_ram_data", ram_data, 32'd0);
      bus.req_valid = 1'b0;
      reset = 1'b0;
      @(negedge clock);
      check("post_rst_ready", 32'(bus.req_ready), 32'd1);

      // Word store/load
      txn("t1_st", 1'b1, 2'd2, 1'b0, 32'h00, 32'h0000_0171, 0);
      txn("t1_ld", 1'b0, 2'd2, 1'b0, 32'h00, 32'h0, 0);

      // Byte RMW and byte loads
      txn("t2_stw", 1'b1, 2'd2, 1'b0, 32'h04, 32'hAABB_CCDD, 0);
      txn("t2_stb", 1'b1, 2'd0, 1'b0, 32'h06, 32'h0000_0011, 0);
      check("t2_ramword", mem[1], 32'hAA11_CCDD);
      txn("t2_lbs", 1'b0, 2'd0, 1'b1, 32'h07, 32'h0, 0);
      txn("t2_lbu", 1'b0, 2'd0, 1'b0, 32'h07, 32'h0, 0);

      // Half RMW into a zero word
      txn("t3_sth", 1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000_8001, 0);
      check("t3_ramword", mem[2], 32'h8001_0000);
      txn("t3_lhs", 1'b0, 2'd1, 1'b1, 32'h0A, 32'h0, 0);

      // Error cases
      txn("t4_mis_w", 1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 0);
      txn("t4_mis_h", 1'b1, 2'd1, 1'b0, 32'h01, 32'h1234, 0);
      txn("t4_size3", 1'b1, 2'd3, 1'b0, 32'h00, 32'hFFFF_FFFF, 0);
      txn("t4_range", 1'b1, 2'd2, 1'b0, 32'h80, 32'h5555_5555, 0);

      // Response backpressure, then back-to-back
      txn("t5_hold", 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 5);
      check("t5_ready_after", 32'(bus.req_ready), 32'd1);
      txn("t5_next", 1'b0, 2'd1, 1'b0, 32'h04, 32'h0, 0);

      // Reset during the write phase of a byte store
      begin
         int w0;
         bus.req_valid = 1'b1;
         bus.req_we    = 1'b1;
         bus.req_size  = 2'd0;
         bus.req_addr  = 32'h05;
         bus.req_wdata = 32'h0000_005A;
         w0 = wren_cnt;
         @(posedge clock);
         @(negedge clock);
         bus.req_valid = 1'b0;
         @(negedge clock);
         @(negedge clock);
         check("t6_in_wr", 32'(ram_wren), 32'd1);
         reset = 1'b1;
         #1;
         check("t6_wren_gated", 32'(ram_wren), 32'd0);
         @(negedge clock);
         reset = 1'b0;
         #1;
         check("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
         check("t6_ready", 32'(bus.req_ready), 32'd1);
         @(negedge clock);
         check("t6_no_write", 32'(wren_cnt - w0), 32'd0);
         check("t6_ramword", mem[1], ref_word(1));
      end
      txn("t6_ld", 1'b0, 2'd2, 1'b0, 32'h04, 32'h0, 0);

      // Random traffic against the reference
      for (int n = 0; n < 80; n++) begin
         logic [1:0]  sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         logic [31:0] a  = 32'($urandom_range(0, 135));
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 1);
         txn($sformatf("rnd%0d", n), 1'($urandom), sz, 1'($urandom), a, $urandom,
             $urandom_range(0, 2));
      end
      for (int i = 0; i < 32; i++) check($sformatf("final_word%0d", i), mem[i], ref_word(i));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
